// File: rtl/ctrl_unit_param.sv
// Multi-cycle control unit: DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK sequencer with an owned register file.
// Optional macro CTRL_ZERO_REG_EN makes reg[0] a hardwired zero register.
module ctrl_unit_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    localparam int INSTR_WIDTH  = 2 + 3*REG_ADDR_BITS + DATA_WIDTH + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [DATA_WIDTH-1:0]    result2,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [DATA_WIDTH-1:0]    offset,
    output logic [3:0]               opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic                     mem_en,
    output logic                     instr_done,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
);

    localparam int NUM_REGS = 1 << REG_ADDR_BITS;
    localparam int OFS_LSB  = 4;
    localparam int S2_LSB   = OFS_LSB + DATA_WIDTH;
    localparam int S1_LSB   = S2_LSB + REG_ADDR_BITS;
    localparam int DST_LSB  = S1_LSB + REG_ADDR_BITS;
    localparam int TYPE_LSB = DST_LSB + REG_ADDR_BITS;

    localparam logic [1:0] T_NOP   = 2'b00;
    localparam logic [1:0] T_STD   = 2'b01;
    localparam logic [1:0] T_LOAD  = 2'b10;
    localparam logic [1:0] T_STORE = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        EXECUTE    = 3'd2,
        MEM_ACCESS = 3'd3,
        WRITE_BACK = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic                     done_nxt;
    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    logic [1:0]               typ;
    logic [REG_ADDR_BITS-1:0] dst_f, src1_f, src2_f;
    logic [DATA_WIDTH-1:0]    ofs_f;
    logic [3:0]               op_f;

    assign typ    = instr_q[TYPE_LSB +: 2];
    assign dst_f  = instr_q[DST_LSB +: REG_ADDR_BITS];
    assign src1_f = instr_q[S1_LSB +: REG_ADDR_BITS];
    assign src2_f = instr_q[S2_LSB +: REG_ADDR_BITS];
    assign ofs_f  = instr_q[OFS_LSB +: DATA_WIDTH];
    assign op_f   = instr_q[3:0];

    function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [REG_ADDR_BITS-1:0] a);
`ifdef CTRL_ZERO_REG_EN
        if (a == '0) return '0;
`endif
        return regs[a];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            instr_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            instr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:       if (instr_valid) state_nxt = DECODE;
            DECODE: begin
                if (typ == T_NOP) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE:    state_nxt = (typ == T_STD) ? WRITE_BACK : MEM_ACCESS;
            MEM_ACCESS: begin
                if (mem_ready) begin
                    if (typ == T_LOAD) begin
                        state_nxt = WRITE_BACK;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        mem_en      = (state == MEM_ACCESS);
    end

    // The instruction is captured only on the accept edge; the bus is ignored while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instr_q <= '0;
        else if (state == IDLE && instr_valid) instr_q <= instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= 4'hF;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
            w_r      <= 1'b0;
        end else if (state == DECODE && typ != T_NOP) begin
            operand1 <= rd_reg(src1_f);
            operand2 <= (typ == T_STD) ? rd_reg(src2_f) : rd_reg(dst_f);
            offset   <= ofs_f;
            opcode   <= op_f;
            sel1     <= (typ == T_STD);
            sel3     <= typ[1];
            w_r      <= (typ == T_STORE);
        end else if (state == MEM_ACCESS && mem_ready) begin
            w_r      <= 1'b0;
        end
    end

    // Write-back lands on the edge leaving WRITE_BACK, so the next DECODE already sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(i);
        end else if (state == WRITE_BACK) begin
`ifdef CTRL_ZERO_REG_EN
            if (dst_f != '0)
`endif
            regs[dst_f] <= result2;
        end
    end

    assign dbg_data = rd_reg(dbg_addr);

endmodule

// File: tb/tb_ctrl_unit_param.sv
// Directed bench for ctrl_unit_param: per-edge checks of handshake, controls, latency and regfile.
module tb_ctrl_unit_param;

    logic        clk;
    logic        rst;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  result2;
    logic        mem_ready;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [7:0]  offset;
    logic [3:0]  opcode;
    logic        sel1;
    logic        sel3;
    logic        w_r;
    logic        mem_en;
    logic        instr_done;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    ctrl_unit_param dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .result2     (result2),
        .mem_ready   (mem_ready),
        .operand1    (operand1),
        .operand2    (operand2),
        .offset      (offset),
        .opcode      (opcode),
        .sel1        (sel1),
        .sel3        (sel3),
        .w_r         (w_r),
        .mem_en      (mem_en),
        .instr_done  (instr_done),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 1);
        chk({tag, "_op1"},   32'(operand1), 0);
        chk({tag, "_op2"},   32'(operand2), 0);
        chk({tag, "_ofs"},   32'(offset), 0);
        chk({tag, "_opc"},   32'(opcode), 'hF);
        chk({tag, "_sel1"},  32'(sel1), 0);
        chk({tag, "_sel3"},  32'(sel3), 0);
        chk({tag, "_wr"},    32'(w_r), 0);
        chk({tag, "_memen"}, 32'(mem_en), 0);
        chk({tag, "_done"},  32'(instr_done), 0);
        for (int i = 0; i < 4; i++) chk_reg({tag, "_reg"}, 2'(i), 32'(i));
    endtask

    function automatic logic [19:0] mk(input logic [1:0] t, input logic [1:0] d,
                                       input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [7:0] o, input logic [3:0] op);
        return {t, d, s1, s2, o, op};
    endfunction

    initial begin
        logic [31:0] zexp;
`ifdef CTRL_ZERO_REG_EN
        zexp = 0;
`else
        zexp = 'hFF;
`endif
        rst = 1'b0; instr_valid = 1'b0; instr = '0;
        result2 = '0; mem_ready = 1'b0; dbg_addr = '0;
        tick; tick;
        chk_reset_outputs("rst");
        rst = 1'b1;
        tick;

        // std_op dst=1 src1=2 src2=3 opcode=2, write-back 0x05
        instr = mk(2'b01, 2'd1, 2'd2, 2'd3, 8'h00, 4'h2); instr_valid = 1'b1; result2 = 8'h05;
        tick;
        chk("std_busy_ready", 32'(instr_ready), 0);
        chk("std_e1_done",    32'(instr_done), 0);
        instr = mk(2'b00, 2'd2, 2'd0, 2'd0, 8'h77, 4'h7);
        tick;
        chk("std_op1",  32'(operand1), 2);
        chk("std_op2",  32'(operand2), 3);
        chk("std_sel1", 32'(sel1), 1);
        chk("std_sel3", 32'(sel3), 0);
        chk("std_opc",  32'(opcode), 2);
        chk("std_wr",   32'(w_r), 0);
        tick;
        chk("std_e3_done", 32'(instr_done), 0);
        instr_valid = 1'b0;
        tick;
        chk("std_e4_done",  32'(instr_done), 1);
        chk("std_e4_ready", 32'(instr_ready), 1);
        chk_reg("std_reg1", 2'd1, 'h05);
        tick;
        chk("std_done_pulse", 32'(instr_done), 0);

        // loadR dst=3 src1=1 offset=0x10, three wait cycles
        instr = mk(2'b10, 2'd3, 2'd1, 2'd0, 8'h10, 4'h0); instr_valid = 1'b1;
        result2 = 8'hA5; mem_ready = 1'b0;
        tick;
        instr_valid = 1'b0;
        chk("ld_e1_done", 32'(instr_done), 0);
        tick;
        chk("ld_op1",   32'(operand1), 'h05);
        chk("ld_op2",   32'(operand2), 3);
        chk("ld_ofs",   32'(offset), 'h10);
        chk("ld_sel1",  32'(sel1), 0);
        chk("ld_sel3",  32'(sel3), 1);
        chk("ld_e2_memen", 32'(mem_en), 0);
        tick;
        chk("ld_e3_memen", 32'(mem_en), 1);
        chk("ld_e3_wr",    32'(w_r), 0);
        tick;
        chk("ld_e4_memen", 32'(mem_en), 1);
        tick;
        chk("ld_e5_memen", 32'(mem_en), 1);
        tick;
        chk("ld_e6_memen", 32'(mem_en), 1);
        chk("ld_e6_done",  32'(instr_done), 0);
        mem_ready = 1'b1;
        tick;
        chk("ld_e7_memen", 32'(mem_en), 0);
        chk("ld_e7_done",  32'(instr_done), 0);
        chk_reg("ld_reg3_pre", 2'd3, 3);
        mem_ready = 1'b0;
        tick;
        chk("ld_e8_done", 32'(instr_done), 1);
        chk_reg("ld_reg3", 2'd3, 'hA5);
        tick;

        // storeR dst=2 src1=0 offset=0x04, zero wait
        instr = mk(2'b11, 2'd2, 2'd0, 2'd0, 8'h04, 4'h3); instr_valid = 1'b1; result2 = 8'h3C;
        tick;
        instr_valid = 1'b0;
        tick;
        chk("st_op1",  32'(operand1), 0);
        chk("st_op2",  32'(operand2), 2);
        chk("st_ofs",  32'(offset), 'h04);
        chk("st_sel1", 32'(sel1), 0);
        chk("st_sel3", 32'(sel3), 1);
        chk("st_e2_wr", 32'(w_r), 1);
        mem_ready = 1'b1;
        tick;
        chk("st_e3_memen", 32'(mem_en), 1);
        chk("st_e3_wr",    32'(w_r), 1);
        chk("st_e3_done",  32'(instr_done), 0);
        tick;
        chk("st_e4_done",  32'(instr_done), 1);
        chk("st_e4_wr",    32'(w_r), 0);
        chk("st_e4_memen", 32'(mem_en), 0);
        chk("st_e4_sel3",  32'(sel3), 1);
        chk_reg("st_reg2", 2'd2, 2);
        mem_ready = 1'b0;

        // NOP accepted in the storeR done cycle, std_op presented during NOP
        instr = mk(2'b00, 2'd1, 2'd1, 2'd1, 8'h99, 4'h9); instr_valid = 1'b1;
        tick;
        chk("nop_e1_ready", 32'(instr_ready), 0);
        chk("nop_e1_done",  32'(instr_done), 0);
        instr = mk(2'b01, 2'd2, 2'd1, 2'd3, 8'h00, 4'h5); result2 = 8'h5A;
        tick;
        chk("nop_e2_done",  32'(instr_done), 1);
        chk("nop_e2_ready", 32'(instr_ready), 1);
        chk("nop_keep_opc", 32'(opcode), 3);
        chk("nop_keep_ofs", 32'(offset), 'h04);
        chk("nop_keep_sel3", 32'(sel3), 1);
        tick;
        chk("b2b_e1_ready", 32'(instr_ready), 0);
        chk("b2b_e1_done",  32'(instr_done), 0);
        instr = mk(2'b11, 2'd0, 2'd0, 2'd0, 8'hEE, 4'hE);
        tick;
        chk("b2b_op1",  32'(operand1), 'h05);
        chk("b2b_op2",  32'(operand2), 'hA5);
        chk("b2b_opc",  32'(opcode), 5);
        chk("b2b_sel1", 32'(sel1), 1);
        chk("b2b_sel3", 32'(sel3), 0);
        tick;
        chk("b2b_e3_done",  32'(instr_done), 0);
        chk("b2b_e3_memen", 32'(mem_en), 0);
        instr_valid = 1'b0;
        tick;
        chk("b2b_e4_done", 32'(instr_done), 1);
        chk_reg("b2b_reg2", 2'd2, 'h5A);
        chk_reg("b2b_reg0", 2'd0, 0);
        tick;
        chk("b2b_done_pulse", 32'(instr_done), 0);

        // reset during MEM_ACCESS of a loadR
        instr = mk(2'b10, 2'd1, 2'd2, 2'd0, 8'h20, 4'h1); instr_valid = 1'b1;
        result2 = 8'hCC; mem_ready = 1'b0;
        tick;
        instr_valid = 1'b0;
        tick;
        tick;
        chk("ab_memen", 32'(mem_en), 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("ab");
        mem_ready = 1'b1;
        tick;
        chk("ab_hold_done", 32'(instr_done), 0);
        rst = 1'b1;
        tick;
        chk("ab_post_done",  32'(instr_done), 0);
        chk("ab_post_ready", 32'(instr_ready), 1);
        chk("ab_post_memen", 32'(mem_en), 0);
        tick;
        chk("ab_post2_done", 32'(instr_done), 0);
        chk_reg("ab_reg1", 2'd1, 1);
        mem_ready = 1'b0;

        // std_op writing reg0
        instr = mk(2'b01, 2'd0, 2'd1, 2'd2, 8'h00, 4'h6); instr_valid = 1'b1; result2 = 8'hFF;
        tick;
        instr_valid = 1'b0;
        tick;
        chk("z_op1", 32'(operand1), 1);
        chk("z_op2", 32'(operand2), 2);
        tick;
        chk("z_e3_done", 32'(instr_done), 0);
        tick;
        chk("z_e4_done", 32'(instr_done), 1);
        chk_reg("z_reg0", 2'd0, zexp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
